// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enc_pkg
// Description : Shared widths and FSM state type for the sequential
//               8-to-3 priority encoder.
//               VEC_W  - width of the request vector
//               IDX_W  - width of a bit index into the vector
//               state_e - IDLE (ready for a vector) / BUSY (emitting beats)
// Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

    localparam int VEC_W = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // One-hot mask selecting bit 'idx' of a VEC_W-wide vector.
    function automatic logic [VEC_W-1:0] idx_mask(input logic [IDX_W-1:0] idx);
        logic [VEC_W-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage : enc_pkg
`default_nettype wire

// File: rtl/pri_sel_8to3.sv
`default_nettype none
// ============================================================================
// Module      : pri_sel_8to3
// Description : Purely combinational priority selector. Returns the index of
//               the highest (msb_first_i=1) or lowest (msb_first_i=0) set bit
//               of vec_i, plus flags telling whether any bit is set and
//               whether exactly one bit is set.
// Ports       : vec_i       - vector to examine
//               msb_first_i - search direction (1 = highest index wins)
//               idx_o       - selected index (0 when vec_i is all zero)
//               any_o       - at least one bit of vec_i is set
//               one_o       - exactly one bit of vec_i is set
// Revision    : 1.0 - initial release
// ============================================================================
module pri_sel_8to3
    import enc_pkg::*;
(
    input  logic [VEC_W-1:0] vec_i,
    input  logic             msb_first_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o,
    output logic             one_o
);

    logic [IDX_W-1:0] w_idx_hi;
    logic [IDX_W-1:0] w_idx_lo;

    // Highest set bit: ascending scan, last hit wins.
    always_comb begin
        w_idx_hi = '0;
        for (int i = 0; i < VEC_W; i++) begin
            if (vec_i[i]) begin
                w_idx_hi = IDX_W'(i);
            end
        end
    end

    // Lowest set bit: descending scan, last hit wins.
    always_comb begin
        w_idx_lo = '0;
        for (int i = VEC_W - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                w_idx_lo = IDX_W'(i);
            end
        end
    end

    assign idx_o = msb_first_i ? w_idx_hi : w_idx_lo;
    assign any_o = |vec_i;
    // Clearing the lowest set bit leaves zero only for a one-hot vector.
    assign one_o = any_o && ((vec_i & (vec_i - VEC_W'(1))) == '0);

endmodule : pri_sel_8to3
`default_nettype wire

// File: rtl/encoder_8to3_seq.sv
`default_nettype none
// ============================================================================
// Module      : encoder_8to3_seq
// Description : Sequential 8-to-3 encoder. Accepts a request vector through a
//               valid/ready handshake and emits one index beat per set bit, in
//               priority order, through a second valid/ready handshake.
// Parameters  : MSB_FIRST - 1: highest set index first, 0: lowest first
// Ports       : clk       - clock, rising edge
//               rst_n     - synchronous active-low reset
//               in_valid  - D holds a vector
//               in_ready  - block can accept a vector (IDLE)
//               D         - request vector
//               out_valid - Y holds a valid index (BUSY)
//               out_ready - consumer takes Y this cycle
//               Y         - current index
//               out_last  - Y is the final index of the vector
//               none      - one-cycle pulse after an all-zero vector is taken
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_8to3_seq
    import enc_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VEC_W-1:0] D,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] Y,
    output logic             out_last,
    output logic             none
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [VEC_W-1:0] p_q, p_d;
    logic [IDX_W-1:0] y_q, y_d;
    logic             last_q, last_d;
    logic             none_q, none_d;

    logic             w_accept;
    logic             w_transfer;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_sel_any;
    logic             w_sel_one;

    assign w_accept   = in_valid  && (state_q == IDLE);
    assign w_transfer = out_ready && (state_q == BUSY);

    // ------------------------------------------------------------------
    // Next pending vector and next FSM state
    // ------------------------------------------------------------------
    always_comb begin
        p_d     = p_q;
        state_d = state_q;
        none_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (D != '0) begin
                        p_d     = D;
                        state_d = BUSY;
                    end else begin
                        // Empty vector: report it, stay idle, no beat.
                        none_d  = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (w_transfer) begin
                    p_d = p_q & ~idx_mask(y_q);
                    if (last_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                p_d     = '0;
                state_d = IDLE;
            end
        endcase
    end

    // The selector looks at the *next* pending vector so that Y and
    // out_last are registered and line up with the state they describe.
    pri_sel_8to3 u_pri_sel (
        .vec_i       (p_d),
        .msb_first_i (MSB_FIRST),
        .idx_o       (w_sel_idx),
        .any_o       (w_sel_any),
        .one_o       (w_sel_one)
    );

    // Y and out_last read zero whenever no beat is being offered.
    always_comb begin
        y_d    = '0;
        last_d = 1'b0;
        if (state_d == BUSY && w_sel_any) begin
            y_d    = w_sel_idx;
            last_d = w_sel_one;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            y_q     <= '0;
            last_q  <= 1'b0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            y_q     <= y_d;
            last_q  <= last_d;
            none_q  <= none_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived from registered state only
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == BUSY);
    assign Y         = y_q;
    assign out_last  = last_q;
    assign none      = none_q;

endmodule : encoder_8to3_seq
`default_nettype wire

// File: tb/tb_encoder_8to3_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder_8to3_seq
// Description : Directed self-checking bench. Two instances share stimulus:
//               one emits MSB first, the other LSB first; each has its own
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_8to3_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] D;
    logic       out_ready;

    logic       m_in_ready, m_out_valid, m_out_last, m_none;
    logic [2:0] m_y;
    logic       l_in_ready, l_out_valid, l_out_last, l_none;
    logic [2:0] l_y;

    int n_chk  = 0;
    int n_fail = 0;

    encoder_8to3_seq #(.MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (m_in_ready),
        .D         (D),
        .out_valid (m_out_valid),
        .out_ready (out_ready),
        .Y         (m_y),
        .out_last  (m_out_last),
        .none      (m_none)
    );

    encoder_8to3_seq #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (l_in_ready),
        .D         (D),
        .out_valid (l_out_valid),
        .out_ready (out_ready),
        .Y         (l_y),
        .out_last  (l_out_last),
        .none      (l_none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs settle 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake-level check of both instances.
    task automatic chk_hs(input string tag, input logic vld, input logic rdy);
        check({tag, " m.out_valid"}, 32'(m_out_valid), 32'(vld));
        check({tag, " m.in_ready"},  32'(m_in_ready),  32'(rdy));
        check({tag, " l.out_valid"}, 32'(l_out_valid), 32'(vld));
        check({tag, " l.in_ready"},  32'(l_in_ready),  32'(rdy));
    endtask

    task automatic chk_beat(input string tag, input int my, input logic ml,
                            input int ly, input logic ll);
        chk_hs(tag, 1'b1, 1'b0);
        check({tag, " m.Y"},    32'(m_y),        32'(my));
        check({tag, " m.last"}, 32'(m_out_last), 32'(ml));
        check({tag, " l.Y"},    32'(l_y),        32'(ly));
        check({tag, " l.last"}, 32'(l_out_last), 32'(ll));
    endtask

    task automatic chk_idle(input string tag);
        chk_hs(tag, 1'b0, 1'b1);
        check({tag, " m.last"}, 32'(m_out_last), 32'd0);
        check({tag, " l.last"}, 32'(l_out_last), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        D         = 8'h00;
        out_ready = 1'b1;

        // ---------------- reset ----------------
        step();
        in_valid = 1'b1;      // must be ignored while in reset
        D        = 8'hA5;
        step();
        chk_idle("reset");
        check("reset m.Y",    32'(m_y),    32'd0);
        check("reset l.Y",    32'(l_y),    32'd0);
        check("reset m.none", 32'(m_none), 32'd0);
        check("reset l.none", 32'(l_none), 32'd0);

        // ---------------- 0010_0100 ----------------
        rst_n = 1'b1;
        D     = 8'b0010_0100;
        step();
        in_valid = 1'b0;
        chk_beat("v24 b0", 5, 1'b0, 2, 1'b0);
        step();
        chk_beat("v24 b1", 2, 1'b1, 5, 1'b1);
        step();
        chk_idle("v24 end");

        // ---------------- 0xFF ----------------
        in_valid = 1'b1;
        D        = 8'hFF;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_beat($sformatf("vff b%0d", i), 7 - i, (i == 7), i, (i == 7));
            step();
        end
        chk_idle("vff end");

        // ---------------- 0x81 with backpressure ----------------
        in_valid  = 1'b1;
        D         = 8'h81;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_beat($sformatf("v81 hold%0d", i), 7, 1'b0, 0, 1'b0);
            step();
        end
        chk_beat("v81 held", 7, 1'b0, 0, 1'b0);
        out_ready = 1'b1;
        step();
        chk_beat("v81 b1", 0, 1'b1, 7, 1'b1);
        step();
        chk_idle("v81 end");

        // ---------------- all-zero vector ----------------
        in_valid = 1'b1;
        D        = 8'h00;
        step();
        in_valid = 1'b0;
        chk_idle("v00");
        check("v00 m.none", 32'(m_none), 32'd1);
        check("v00 l.none", 32'(l_none), 32'd1);
        step();
        chk_idle("v00 after");
        check("v00 m.none clr", 32'(m_none), 32'd0);
        check("v00 l.none clr", 32'(l_none), 32'd0);

        // ---------------- 0x0E aborted by reset ----------------
        in_valid = 1'b1;
        D        = 8'h0E;
        step();
        in_valid = 1'b0;
        chk_beat("v0e b0", 3, 1'b0, 1, 1'b0);
        step();
        chk_beat("v0e b1", 2, 1'b0, 2, 1'b0);
        rst_n = 1'b0;
        step();
        chk_idle("v0e rst");
        rst_n = 1'b1;
        step();
        chk_idle("v0e post");
        check("v0e m.none", 32'(m_none), 32'd0);

        // ---------------- 0x03 then 0x10 held while busy ----------------
        in_valid = 1'b1;
        D        = 8'h03;
        step();
        D = 8'h10;            // stays valid, must wait for in_ready
        chk_beat("v03 b0", 1, 1'b0, 0, 1'b0);
        step();
        chk_beat("v03 b1", 0, 1'b1, 1, 1'b1);
        step();
        chk_idle("v03 gap");
        step();
        in_valid = 1'b0;
        chk_beat("v10", 4, 1'b1, 4, 1'b1);
        step();
        chk_idle("v10 end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_encoder_8to3_seq
`default_nettype wire
